fifo_rd_ptr_ctrl: RTL and testbench
===================================

# fifo_rd_ptr_ctrl

Read-side pointer and flag controller for an asynchronous FIFO. Consumes the Gray-coded write pointer produced in the write clock domain, synchronises it into the read domain, converts it back to binary, and maintains the read pointer, read address, EMPTY flag and occupancy count. Its own Gray-coded read pointer is exported for the write side's full logic.

## Interface
- ADDR_W, 3, FIFO address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits wide.
- CLK  in  1  read-domain clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- WPTR_GRAY  in  ADDR_W+1  Gray-coded write pointer, asynchronous to CLK.
- RD_EN  in  1  read request.
- RPTR_GRAY  out  ADDR_W+1  registered Gray-coded read pointer.
- RADDR  out  ADDR_W  RAM read address = read binary pointer [ADDR_W-1:0].
- EMPTY  out  1  registered empty flag.
- COUNT  out  ADDR_W+1  registered occupancy, 0..2^ADDR_W.
- UNDERFLOW  out  1  one-cycle pulse when a read is requested while EMPTY.

## Operation
- Sync: WPTR_GRAY → wq1 → wq2, two flops, no logic between them.
- wbin = Gray-to-binary(wq2): wbin[ADDR_W] = wq2[ADDR_W]; wbin[i] = wbin[i+1] ^ wq2[i].
- rd_fire = RD_EN & ~EMPTY. rbin_next = rbin + rd_fire, modulo 2^(ADDR_W+1) (natural wrap).
- rgray_next = rbin_next ^ (rbin_next >> 1).
- Each edge: rbin <= rbin_next; RPTR_GRAY <= rgray_next; EMPTY <= (rgray_next == wq2); COUNT <= wbin − rbin_next, modulo 2^(ADDR_W+1); UNDERFLOW <= RD_EN & EMPTY.
- Invariant: EMPTY == (COUNT == 0) on every cycle.
- RD_EN while EMPTY: pointer, RADDR, RPTR_GRAY unchanged; UNDERFLOW asserted next cycle only.
- COUNT never exceeds 2^ADDR_W, provided the write side honours its full flag.
- Upstream guarantees at most one WPTR_GRAY bit changes per write-clock edge; no other CDC handling is required here.
- Reset (RST_N low, asynchronous, any time including mid-read): wq1, wq2, rbin, RPTR_GRAY, COUNT = 0; EMPTY = 1; UNDERFLOW = 0; RADDR = 0. The first edge after release behaves as from an empty FIFO.

## Timing
- A read accepted at edge k: RADDR, RPTR_GRAY, COUNT and EMPTY show the new state immediately after edge k. RAM data for the new RADDR is the RAM's concern.
- WPTR_GRAY change stable before edge n: sampled into wq1 at n, into wq2 at n+1; EMPTY/COUNT reflect it after edge n+2 (3-edge latency).
- Simultaneous read and write-pointer advance: rd_fire uses the EMPTY registered before the edge; COUNT = new wbin − rbin_next, so it is unchanged when both advance by one.
- Wrap: rbin 2^(ADDR_W+1)−1 → 0; the Gray pointer changes by one bit; COUNT arithmetic is modular and stays correct.
- UNDERFLOW: high for exactly one cycle per offending RD_EN cycle.

## Structure
- Shared package fifo_ptr_pkg: bin2gray and gray2bin functions, parameterised on width. The write-side controller uses the same package.
- One sub-module: Gray2Bin (parameter NUM_PIN = ADDR_W), combinational, converting wq2 to wbin. The synchroniser stays inline.
- No FSM; state is wq1, wq2, rbin and the registered outputs.

## Test plan
- Reset: assert RST_N low mid-stream with COUNT=5 → outputs go immediately (no clock) to EMPTY=1, COUNT=0, RPTR_GRAY=0000, RADDR=0, UNDERFLOW=0.
- Latency (ADDR_W=3): WPTR_GRAY 0000→0001 before edge n → EMPTY=1 and COUNT=0 after n and n+1; EMPTY=0 and COUNT=1 after n+2.
- Drain: WPTR_GRAY=1100 (bin 8) → COUNT=8. Hold RD_EN for 8 cycles → RADDR 0..7, then back to 0. RPTR_GRAY steps 0001,0011,0010,0110,0111,0101,0100,1100; EMPTY=1 and COUNT=0 after the 8th read.
- Underflow: EMPTY=1, RD_EN=1 for 2 cycles → UNDERFLOW=1 for those 2 cycles; rbin, RPTR_GRAY, RADDR unchanged.
- Wrap: rbin=15 (RPTR_GRAY=1000), WPTR_GRAY=0000 (bin 0), COUNT=1; one read → rbin=0, RPTR_GRAY=0000, RADDR=0, EMPTY=1, COUNT=0.
- Concurrent: COUNT=3; write pointer advances by 1 (one Gray bit) and one read fires in the same cycle → COUNT stays 3; read pointer +1.

Source files
------------

// File: rtl/fifo_ptr_pkg.sv
// Pointer helpers shared by the read- and write-side controllers of the async FIFO.
// Inputs are zero-extended to PTR_MAX_W, so the same functions serve any pointer width.
package fifo_ptr_pkg;

  localparam int PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // The zero upper bits of an extended Gray value decode to zero, so the result stays exact.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ptr_ctrl_if.sv
// Read-side pointer bundle: the write pointer and read request in, the read pointer and flags out.
interface fifo_rd_ptr_ctrl_if #(
  parameter int ADDR_W = 3
);

  logic [ADDR_W:0]   wptr_gray;
  logic              rd_en;
  logic [ADDR_W:0]   rptr_gray;
  logic [ADDR_W-1:0] raddr;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              underflow;

  modport master (
    output wptr_gray, rd_en,
    input  rptr_gray, raddr, empty, count, underflow
  );

  modport slave (
    input  wptr_gray, rd_en,
    output rptr_gray, raddr, empty, count, underflow
  );

endinterface

// File: rtl/Gray2Bin.sv
// Combinational Gray-to-binary decoder for a NUM_PIN+1 bit FIFO pointer.
module Gray2Bin
  import fifo_ptr_pkg::*;
#(
  parameter int NUM_PIN = 3
) (
  input  logic [NUM_PIN:0] gray,
  output logic [NUM_PIN:0] bin
);

  assign bin = (NUM_PIN + 1)'(gray2bin(ptr_max_t'(gray)));

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer/flag controller of an async FIFO: syncs the write Gray pointer in,
// advances the read pointer on accepted reads, and registers EMPTY, COUNT and UNDERFLOW.
module fifo_rd_ptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_rd_ptr_ctrl_if.slave bus
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wq1;
  logic [PW-1:0] wq2;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic          rd_fire;

  Gray2Bin #(
    .NUM_PIN (ADDR_W)
  ) u_gray2bin (
    .gray (wq2),
    .bin  (wbin)
  );

  // EMPTY here is the registered flag, so a read is judged against the state before this edge.
  assign rd_fire    = bus.rd_en & ~bus.empty;
  assign rbin_next  = rbin + PW'(rd_fire);
  assign rgray_next = PW'(bin2gray(ptr_max_t'(rbin_next)));
  assign bus.raddr  = rbin[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq1           <= '0;
      wq2           <= '0;
      rbin          <= '0;
      bus.rptr_gray <= '0;
      bus.empty     <= 1'b1;
      bus.count     <= '0;
      bus.underflow <= 1'b0;
    end else begin
      wq1           <= bus.wptr_gray;
      wq2           <= wq1;
      rbin          <= rbin_next;
      bus.rptr_gray <= rgray_next;
      // Comparing Gray codes directly avoids waiting on the decoder for the empty test.
      bus.empty     <= (rgray_next == wq2);
      bus.count     <= wbin - rbin_next;
      bus.underflow <= bus.rd_en & bus.empty;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Directed bench for fifo_rd_ptr_ctrl: a vector table walked edge by edge plus an async reset sequence.
module tb_fifo_rd_ptr_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  fifo_rd_ptr_ctrl_if #(.ADDR_W(3)) bus ();

  fifo_rd_ptr_ctrl #(.ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] wg;
    logic       rd;
    logic [3:0] rg;
    logic [2:0] ra;
    logic       em;
    logic [3:0] cnt;
    logic       uf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] wg, input logic rd, input logic [3:0] rg,
                     input logic [2:0] ra, input logic em, input logic [3:0] cnt,
                     input logic uf);
    vec_t v;
    v.wg = wg; v.rd = rd; v.rg = rg; v.ra = ra; v.em = em; v.cnt = cnt; v.uf = uf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] rg, input logic [2:0] ra,
                         input logic em, input logic [3:0] cnt, input logic uf);
    chk({tag, " rptr_gray"}, 8'(bus.rptr_gray), 8'(rg));
    chk({tag, " raddr"},     8'(bus.raddr),     8'(ra));
    chk({tag, " empty"},     8'(bus.empty),     8'(em));
    chk({tag, " count"},     8'(bus.count),     8'(cnt));
    chk({tag, " underflow"}, 8'(bus.underflow), 8'(uf));
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.wptr_gray = 4'b0000;
    bus.rd_en     = 1'b0;

    // Latency: write pointer 0 -> 1 visible after the third edge
    add(4'h1, 0, 4'h0, 3'd0, 1, 4'd0, 0);
    add(4'h1, 0, 4'h0, 3'd0, 1, 4'd0, 0);
    add(4'h1, 0, 4'h0, 3'd0, 0, 4'd1, 0);
    // Fill to 8 (Gray 1100), then drain with 8 back-to-back reads
    add(4'hC, 0, 4'h0, 3'd0, 0, 4'd1, 0);
    add(4'hC, 0, 4'h0, 3'd0, 0, 4'd1, 0);
    add(4'hC, 0, 4'h0, 3'd0, 0, 4'd8, 0);
    add(4'hC, 1, 4'b0001, 3'd1, 0, 4'd7, 0);
    add(4'hC, 1, 4'b0011, 3'd2, 0, 4'd6, 0);
    add(4'hC, 1, 4'b0010, 3'd3, 0, 4'd5, 0);
    add(4'hC, 1, 4'b0110, 3'd4, 0, 4'd4, 0);
    add(4'hC, 1, 4'b0111, 3'd5, 0, 4'd3, 0);
    add(4'hC, 1, 4'b0101, 3'd6, 0, 4'd2, 0);
    add(4'hC, 1, 4'b0100, 3'd7, 0, 4'd1, 0);
    add(4'hC, 1, 4'b1100, 3'd0, 1, 4'd0, 0);
    // Underflow: two reads while empty, pointer frozen
    add(4'hC, 1, 4'b1100, 3'd0, 1, 4'd0, 1);
    add(4'hC, 1, 4'b1100, 3'd0, 1, 4'd0, 1);
    add(4'hC, 0, 4'b1100, 3'd0, 1, 4'd0, 0);
    // Write pointer to bin 15 (Gray 1000), read up to rbin 15
    add(4'h8, 0, 4'b1100, 3'd0, 1, 4'd0, 0);
    add(4'h8, 0, 4'b1100, 3'd0, 1, 4'd0, 0);
    add(4'h8, 0, 4'b1100, 3'd0, 0, 4'd7, 0);
    add(4'h8, 1, 4'b1101, 3'd1, 0, 4'd6, 0);
    add(4'h8, 1, 4'b1111, 3'd2, 0, 4'd5, 0);
    add(4'h8, 1, 4'b1110, 3'd3, 0, 4'd4, 0);
    add(4'h8, 1, 4'b1010, 3'd4, 0, 4'd3, 0);
    add(4'h8, 1, 4'b1011, 3'd5, 0, 4'd2, 0);
    add(4'h8, 1, 4'b1001, 3'd6, 0, 4'd1, 0);
    add(4'h8, 1, 4'b1000, 3'd7, 1, 4'd0, 0);
    // Wrap: write pointer wraps to 0, COUNT = 0 - 15 = 1, one read wraps rbin to 0
    add(4'h0, 0, 4'b1000, 3'd7, 1, 4'd0, 0);
    add(4'h0, 0, 4'b1000, 3'd7, 1, 4'd0, 0);
    add(4'h0, 0, 4'b1000, 3'd7, 0, 4'd1, 0);
    add(4'h0, 1, 4'b0000, 3'd0, 1, 4'd0, 0);
    // Concurrent: COUNT=3, write advance and read land on the same edge
    add(4'h2, 0, 4'b0000, 3'd0, 1, 4'd0, 0);
    add(4'h2, 0, 4'b0000, 3'd0, 1, 4'd0, 0);
    add(4'h2, 0, 4'b0000, 3'd0, 0, 4'd3, 0);
    add(4'h6, 0, 4'b0000, 3'd0, 0, 4'd3, 0);
    add(4'h6, 0, 4'b0000, 3'd0, 0, 4'd3, 0);
    add(4'h6, 1, 4'b0001, 3'd1, 0, 4'd3, 0);
    add(4'h6, 0, 4'b0001, 3'd1, 0, 4'd3, 0);
    // Bring COUNT to 5 ahead of the mid-stream reset
    add(4'h5, 0, 4'b0001, 3'd1, 0, 4'd3, 0);
    add(4'h5, 0, 4'b0001, 3'd1, 0, 4'd3, 0);
    add(4'h5, 0, 4'b0001, 3'd1, 0, 4'd5, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_all("init_reset", 4'h0, 3'd0, 1, 4'd0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.wptr_gray = vecs[i].wg;
      bus.rd_en     = vecs[i].rd;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].rg, vecs[i].ra, vecs[i].em,
              vecs[i].cnt, vecs[i].uf);
    end

    // Asynchronous reset mid-read with COUNT=5: outputs clear without a clock edge
    bus.rd_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 4'h0, 3'd0, 1, 4'd0, 0);
    @(posedge clk);
    #1;
    chk_all("held_reset", 4'h0, 3'd0, 1, 4'd0, 0);

    // After release the synchroniser restarts from 0, so bin 6 shows up on the third edge
    rst_n     = 1'b1;
    bus.rd_en = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_reset1", 4'h0, 3'd0, 1, 4'd0, 0);
    @(posedge clk);
    #1;
    chk_all("post_reset2", 4'h0, 3'd0, 1, 4'd0, 0);
    @(posedge clk);
    #1;
    chk_all("post_reset3", 4'h0, 3'd0, 0, 4'd6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
